// File: rtl/d_in_conditioner.sv
// ============================================================================
// Module   : d_in_conditioner
// Brief    : Synchronises, debounces and edge-detects a raw switch level.
//            Optional rising-event counter enabled by DIN_COND_EVT_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module d_in_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    output logic             d_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int TIMER_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   d_out_q, d_out_d;
    logic                   rise_pulse_q, rise_pulse_d;
    logic                   fall_pulse_q, fall_pulse_d;
    logic                   d_sync;

    assign d_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], d_in};
        state_d      = state_q;
        timer_d      = timer_q;
        d_out_d      = d_out_q;
        rise_pulse_d = 1'b0;
        fall_pulse_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (d_sync) begin
                    state_d = ST_RISE_WAIT;
                    timer_d = '0;
                end
            end
            ST_RISE_WAIT: begin
                // A reverting sample wins over timer expiry: glitch rejected.
                if (!d_sync) begin
                    state_d = ST_LOW;
                end else if (timer_q == c_timer_last) begin
                    state_d      = ST_HIGH;
                    d_out_d      = 1'b1;
                    rise_pulse_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_HIGH: begin
                if (!d_sync) begin
                    state_d = ST_FALL_WAIT;
                    timer_d = '0;
                end
            end
            ST_FALL_WAIT: begin
                if (d_sync) begin
                    state_d = ST_HIGH;
                end else if (timer_q == c_timer_last) begin
                    state_d      = ST_LOW;
                    d_out_d      = 1'b0;
                    fall_pulse_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            state_q      <= ST_LOW;
            timer_q      <= '0;
            d_out_q      <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            d_out_q      <= d_out_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
        end
    end

    assign d_out      = d_out_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;

`ifdef DIN_COND_EVT_CNT_EN
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    // Counts on the same edge that raises rise_pulse; wraps silently.
    always_comb begin
        evt_cnt_d = evt_cnt_q + CNT_W'(rise_pulse_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`else
    assign evt_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_d_in_conditioner.sv
// ============================================================================
// Module   : tb_d_in_conditioner
// Brief    : Self-checking bench for d_in_conditioner against a run-length model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_d_in_conditioner;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 8;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;  // edge index of d_out change

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             d_in = 1'b0;
    logic             d_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] evt_cnt;

    int tests = 0;
    int fails = 0;

    d_in_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .d_out     (d_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .evt_cnt   (evt_cnt)
    );

    always #5 clk = ~clk;

    // Reference: d_sync is d_in delayed SYNC_STAGES edges; a new level is
    // accepted after DEBOUNCE_CYCLES+1 consecutive samples that differ from d_out.
    logic             m_sync[$];
    int               m_run;
    logic             m_out, m_rise, m_fall;
    logic [CNT_W-1:0] m_cnt;

    wire [CNT_W+2:0] obs = {d_out, rise_pulse, fall_pulse, evt_cnt};

    function automatic logic [CNT_W+2:0] exp_vec();
`ifdef DIN_COND_EVT_CNT_EN
        return {m_out, m_rise, m_fall, m_cnt};
`else
        return {m_out, m_rise, m_fall, {CNT_W{1'b0}}};
`endif
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt_of(input logic [CNT_W-1:0] c);
`ifdef DIN_COND_EVT_CNT_EN
        return c;
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_sync.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back(1'b0);
        m_run  = 0;
        m_out  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic tick(input logic din, input logic r);
        logic ds;
        d_in = din;
        rst  = r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            ds = m_sync.pop_front();
            m_sync.push_back(din);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (ds != m_out) begin
                m_run++;
                if (m_run == DEBOUNCE_CYCLES + 1) begin
                    m_out = ds;
                    m_run = 0;
                    if (ds) begin
                        m_rise = 1'b1;
                        m_cnt  = m_cnt + 1'b1;
                    end else begin
                        m_fall = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            tests++;
            if (obs !== '0) begin
                fails++;
                $display("FAIL reset cyc%0d obs=%h exp=0", i, obs);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL reset_settle cyc%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_rise_latency();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0);
            tests++;
            if (obs !== exp_vec() || rise_pulse !== (i == LAT) || d_out !== (i >= LAT)) begin
                fails++;
                $display("FAIL rise_latency edge%0d obs=%h exp=%h rise=%b d_out=%b", i, obs,
                         exp_vec(), rise_pulse, d_out);
            end
        end
        tests++;
        if (evt_cnt !== exp_cnt_of(CNT_W'(1))) begin
            fails++;
            $display("FAIL rise_evt_cnt obs=%0d exp=%0d", evt_cnt, exp_cnt_of(CNT_W'(1)));
        end
    endtask

    task automatic test_fall_latency();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            tests++;
            if (obs !== exp_vec() || fall_pulse !== (i == LAT) || d_out !== (i < LAT) ||
                rise_pulse !== 1'b0 || evt_cnt !== exp_cnt_of(CNT_W'(1))) begin
                fails++;
                $display("FAIL fall_latency edge%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        int rises;
        for (int hold = DEBOUNCE_CYCLES; hold <= DEBOUNCE_CYCLES + 1; hold++) begin
            rises = 0;
            for (int i = 0; i < hold + 16; i++) begin
                tick(i < hold, 1'b0);
                if (rise_pulse === 1'b1) rises++;
                tests++;
                if (obs !== exp_vec()) begin
                    fails++;
                    $display("FAIL glitch hold%0d cyc%0d obs=%h exp=%h", hold, i, obs, exp_vec());
                end
            end
            tests++;
            if (rises != ((hold > DEBOUNCE_CYCLES) ? 1 : 0)) begin
                fails++;
                $display("FAIL glitch_pulses hold%0d obs=%0d exp=%0d", hold, rises,
                         (hold > DEBOUNCE_CYCLES) ? 1 : 0);
            end
        end
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] start;
        int               errs;
        start = evt_cnt;
        errs  = 0;
        for (int e = 0; e < 256; e++) begin
            for (int i = 0; i < 16; i++) begin
                tick(i < 8, 1'b0);
                tests++;
                if (obs !== exp_vec()) begin
                    fails++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL wrap ev%0d cyc%0d obs=%h exp=%h", e, i, obs, exp_vec());
                end
            end
        end
        tests++;
        if (evt_cnt !== start) begin
            fails++;
            $display("FAIL wrap_final obs=%0d exp=%0d", evt_cnt, start);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1);
            tests++;
            if (obs !== '0) begin
                fails++;
                $display("FAIL reset_mid_in_rst cyc%0d obs=%h exp=0", i, obs);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            tests++;
            if (obs !== exp_vec() || rise_pulse !== (i == LAT) || d_out !== (i >= LAT)) begin
                fails++;
                $display("FAIL reset_mid edge%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic lvl;
        int   len;
        int   errs;
        lvl  = d_in;
        errs = 0;
        for (int n = 0; n < 300; n++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 2 * DEBOUNCE_CYCLES + 2);
            for (int i = 0; i < len; i++) begin
                tick(lvl, ($urandom_range(0, 99) == 0));
                tests++;
                if (obs !== exp_vec()) begin
                    fails++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL random run%0d cyc%0d obs=%h exp=%h", n, i, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise_latency();
        test_fall_latency();
        test_glitch();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
